// File: rtl/sys_top.sv
// sys_top: UART command processor driving a 16x8 register file and a 16-bit ALU.
// Define SYS_TOP_PARITY_EN for 11-bit even-parity frames; otherwise 10-bit frames.
module sys_top #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic REF_CLK,
    input  logic RST,
    input  logic RX_IN,
    output logic TX_OUT,
    output logic PAR_ERR,
    output logic FRM_ERR,
    output logic BUSY
);
`ifdef SYS_TOP_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_st_e;
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, OPA, OPB, FUNC, EXEC, TX} st_e;

    rx_st_e        rx_st_q, rx_st_d;
    logic          rx_s1_q, rx_s2_q, seen_hi_q, seen_hi_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_vld_q, rx_vld_d, frm_err_q, frm_err_d;
    logic          rx_tick, rx_err;
`ifdef SYS_TOP_PARITY_EN
    logic          rx_pok_q, rx_pok_d, par_err_q, par_err_d;
`endif

    assign rx_tick = (rx_cnt_q == CW'(CLKS_PER_BIT - 1));

    // The line must be seen high in IDLE before a low counts as a start bit;
    // this also keeps a low stop bit from being taken as the next start.
    always_comb begin
        rx_st_d   = rx_st_q;
        rx_cnt_d  = rx_tick ? '0 : rx_cnt_q + 1'b1;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        seen_hi_d = 1'b0;
        rx_vld_d  = 1'b0;
        frm_err_d = 1'b0;
`ifdef SYS_TOP_PARITY_EN
        rx_pok_d  = rx_pok_q;
        par_err_d = 1'b0;
`endif
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d  = '0;
                seen_hi_d = seen_hi_q | rx_s2_q;
                if (seen_hi_q && !rx_s2_q) rx_st_d = RX_START;
            end
            RX_START: begin
                if (rx_s2_q) rx_st_d = RX_IDLE;
                else if (rx_cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                    rx_st_d  = RX_DATA;
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                end
            end
            RX_DATA: if (rx_tick) begin
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7)
`ifdef SYS_TOP_PARITY_EN
                    rx_st_d = RX_PAR;
`else
                    rx_st_d = RX_STOP;
`endif
            end
`ifdef SYS_TOP_PARITY_EN
            RX_PAR: if (rx_tick) begin
                rx_pok_d = (rx_s2_q == ^rx_sh_q);
                rx_st_d  = RX_STOP;
            end
`endif
            RX_STOP: if (rx_tick) begin
                rx_st_d   = RX_IDLE;
                frm_err_d = !rx_s2_q;
`ifdef SYS_TOP_PARITY_EN
                par_err_d = !rx_pok_q;
                rx_vld_d  = rx_s2_q & rx_pok_q;
`else
                rx_vld_d  = rx_s2_q;
`endif
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge REF_CLK) begin
        if (RST) begin
            rx_s1_q <= 1'b0;  rx_s2_q <= 1'b0;  seen_hi_q <= 1'b0;
            rx_st_q <= RX_IDLE;  rx_cnt_q <= '0;  rx_bit_q <= '0;  rx_sh_q <= '0;
            rx_vld_q <= 1'b0;  frm_err_q <= 1'b0;
`ifdef SYS_TOP_PARITY_EN
            rx_pok_q <= 1'b1;  par_err_q <= 1'b0;
`endif
        end else begin
            rx_s1_q <= RX_IN;  rx_s2_q <= rx_s1_q;  seen_hi_q <= seen_hi_d;
            rx_st_q <= rx_st_d;  rx_cnt_q <= rx_cnt_d;  rx_bit_q <= rx_bit_d;  rx_sh_q <= rx_sh_d;
            rx_vld_q <= rx_vld_d;  frm_err_q <= frm_err_d;
`ifdef SYS_TOP_PARITY_EN
            rx_pok_q <= rx_pok_d;  par_err_q <= par_err_d;
`endif
        end
    end

`ifdef SYS_TOP_PARITY_EN
    assign rx_err  = frm_err_q | par_err_q;
    assign PAR_ERR = par_err_q;
`else
    assign rx_err  = frm_err_q;
    assign PAR_ERR = 1'b0;
`endif
    assign FRM_ERR = frm_err_q;

    st_e         st_q, st_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [3:0]  addr_q, addr_d, func_q, func_d;
    logic [15:0] res_q, res_d, alu;
    logic        two_q, two_d, we, tx_load, cmd_ok;
    logic [3:0]  wa;
    logic [7:0]  regs_q [16];
    logic        tx_act_q, tx_out_q, tx_pend_q;
    logic [NBITS-2:0] tx_sh_q;
    logic [CW-1:0]    tx_cnt_q;
    logic [3:0]       tx_bit_q;
    logic [7:0]       tx_hi_q;

    assign cmd_ok = (rx_sh_q == 8'hAA) || (rx_sh_q == 8'hBB) || (rx_sh_q == 8'hCC) || (rx_sh_q == 8'hDD);

    always_comb begin
        st_d    = st_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        func_d  = func_q;
        res_d   = res_q;
        two_d   = two_q;
        we      = 1'b0;
        wa      = addr_q;
        tx_load = 1'b0;
        case (st_q)
            IDLE: if (rx_vld_q && cmd_ok) begin
                cmd_d = rx_sh_q;
                case (rx_sh_q)
                    8'hCC:   st_d = OPA;
                    8'hDD:   st_d = FUNC;
                    default: st_d = ADDR;
                endcase
            end
            ADDR: if (rx_vld_q) begin
                addr_d = rx_sh_q[3:0];
                st_d   = (cmd_q == 8'hBB) ? EXEC : WDATA;
            end
            WDATA: if (rx_vld_q) begin we = 1'b1; st_d = IDLE; end
            OPA:   if (rx_vld_q) begin we = 1'b1; wa = 4'd0; st_d = OPB; end
            OPB:   if (rx_vld_q) begin we = 1'b1; wa = 4'd1; st_d = FUNC; end
            FUNC:  if (rx_vld_q) begin func_d = rx_sh_q[3:0]; st_d = EXEC; end
            // Hold here until the previous response has fully left the wire.
            EXEC: if (!tx_act_q) begin
                res_d = (cmd_q == 8'hBB) ? {8'h00, regs_q[addr_q]} : alu;
                two_d = (cmd_q != 8'hBB);
                st_d  = TX;
            end
            TX: begin tx_load = 1'b1; st_d = IDLE; end
            default: st_d = IDLE;
        endcase
        if (rx_err && st_q != EXEC && st_q != TX) st_d = IDLE;
    end

    always_comb begin
        alu = 16'h0;
        case (func_q)
            4'h0: alu = {8'h00, regs_q[0]} + {8'h00, regs_q[1]};
            4'h1: alu = {8'h00, regs_q[0]} - {8'h00, regs_q[1]};
            4'h2: alu = {8'h00, regs_q[0]} * {8'h00, regs_q[1]};
            4'h3: alu = (regs_q[1] == 8'h00) ? 16'h0 : {8'h00, regs_q[0] / regs_q[1]};
            4'h4: alu = {8'h00, regs_q[0] & regs_q[1]};
            4'h5: alu = {8'h00, regs_q[0] | regs_q[1]};
            4'h6: alu = {8'h00, ~(regs_q[0] & regs_q[1])};
            4'h7: alu = {8'h00, ~(regs_q[0] | regs_q[1])};
            4'h8: alu = {8'h00, regs_q[0] ^ regs_q[1]};
            4'h9: alu = {8'h00, ~(regs_q[0] ^ regs_q[1])};
            4'hA: alu = {15'h0, regs_q[0] == regs_q[1]};
            4'hB: alu = {15'h0, regs_q[0] > regs_q[1]};
            4'hC: alu = {15'h0, regs_q[0] < regs_q[1]};
            4'hD: alu = {9'h000, regs_q[0][7:1]};
            4'hE: alu = {7'h00, regs_q[0], 1'b0};
            default: alu = 16'h0;
        endcase
    end

    always_ff @(posedge REF_CLK) begin
        if (RST) begin
            st_q <= IDLE;  cmd_q <= '0;  addr_q <= '0;  func_q <= '0;  res_q <= '0;  two_q <= 1'b0;
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
            regs_q[2] <= 8'h81;
            regs_q[3] <= 8'h20;
        end else begin
            st_q <= st_d;  cmd_q <= cmd_d;  addr_q <= addr_d;  func_q <= func_d;  res_q <= res_d;  two_q <= two_d;
            if (we) regs_q[wa] <= rx_sh_q;
        end
    end

    function automatic logic [NBITS-2:0] frame(input logic [7:0] d);
`ifdef SYS_TOP_PARITY_EN
        return {1'b1, ^d, d};
`else
        return {1'b1, d};
`endif
    endfunction

    // tx_sh_q holds the bits after the start bit; the MSB frame reloads it back-to-back.
    always_ff @(posedge REF_CLK) begin
        if (RST) begin
            tx_act_q <= 1'b0;  tx_out_q <= 1'b1;  tx_pend_q <= 1'b0;  tx_sh_q <= '1;
            tx_cnt_q <= '0;  tx_bit_q <= '0;  tx_hi_q <= '0;
        end else if (tx_load) begin
            tx_act_q <= 1'b1;  tx_out_q <= 1'b0;  tx_sh_q <= frame(res_q[7:0]);
            tx_hi_q <= res_q[15:8];  tx_pend_q <= two_q;  tx_cnt_q <= '0;  tx_bit_q <= '0;
        end else if (tx_act_q) begin
            if (tx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'(NBITS - 1)) begin
                    if (tx_pend_q) begin
                        tx_out_q <= 1'b0;  tx_sh_q <= frame(tx_hi_q);  tx_pend_q <= 1'b0;  tx_bit_q <= '0;
                    end else begin
                        tx_act_q <= 1'b0;  tx_out_q <= 1'b1;
                    end
                end else begin
                    tx_out_q <= tx_sh_q[0];
                    tx_sh_q  <= {1'b1, tx_sh_q[NBITS-2:1]};
                    tx_bit_q <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    assign TX_OUT = tx_out_q;
    assign BUSY   = (st_q != IDLE) || tx_act_q || (rx_vld_q && cmd_ok);
endmodule

// File: tb/tb_sys_top.sv
// Bench for sys_top: directed command sequences plus randomized commands,
// with a serial monitor that decodes TX_OUT and checks it against a register/ALU model.
module tb_sys_top;
    localparam int CPB = 8;
`ifdef SYS_TOP_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic REF_CLK = 1'b0;
    logic RST, RX_IN, TX_OUT, PAR_ERR, FRM_ERR, BUSY;

    sys_top #(.CLKS_PER_BIT(CPB)) dut (
        .REF_CLK(REF_CLK), .RST(RST), .RX_IN(RX_IN), .TX_OUT(TX_OUT),
        .PAR_ERR(PAR_ERR), .FRM_ERR(FRM_ERR), .BUSY(BUSY)
    );

    always #5 REF_CLK = ~REF_CLK;

    typedef struct packed { logic ch; logic [7:0] d; } exp_t;
    exp_t exp_q[$];
    logic [7:0] regs_m [16];
    int checks = 0, fails = 0, cyc = 0, par_n = 0, frm_n = 0;
    bit mon_ignore = 0, mon_busy = 0, chk_busy = 0;

    always @(posedge REF_CLK) cyc <= cyc + 1;
    always @(negedge REF_CLK) begin
        if (PAR_ERR === 1'b1) par_n++;
        if (FRM_ERR === 1'b1) frm_n++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] alu_ref(input int a, input int b, input int f);
        case (f)
            0: return 16'(a + b);
            1: return 16'(a - b);
            2: return 16'(a * b);
            3: return (b == 0) ? 16'h0 : 16'(a / b);
            4: return 16'(a & b);
            5: return 16'(a | b);
            6: return 16'(~(a & b) & 255);
            7: return 16'(~(a | b) & 255);
            8: return 16'(a ^ b);
            9: return 16'(~(a ^ b) & 255);
            10: return (a == b) ? 16'h1 : 16'h0;
            11: return (a > b) ? 16'h1 : 16'h0;
            12: return (a < b) ? 16'h1 : 16'h0;
            13: return 16'(a / 2);
            14: return 16'(a * 2);
            default: return 16'h0;
        endcase
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 16; i++) regs_m[i] = 8'h00;
        regs_m[2] = 8'h81;
        regs_m[3] = 8'h20;
    endtask

    // err[0]: flip parity bit, err[1]: drive stop bit low
    task automatic send_byte(input logic [7:0] d, input logic [1:0] err);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
`ifdef SYS_TOP_PARITY_EN
        f[9]  = (^d) ^ err[0];
        f[10] = ~err[1];
`else
        f[9]  = ~err[1];
`endif
        for (int i = 0; i < NBITS; i++) begin
            RX_IN = f[i];
            repeat (CPB) @(negedge REF_CLK);
        end
        RX_IN = 1'b1;
        repeat (2) @(negedge REF_CLK);
    endtask

    task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
        regs_m[a[3:0]] = d;
        send_byte(8'hAA, 2'b00); send_byte(a, 2'b00); send_byte(d, 2'b00);
    endtask

    task automatic cmd_read(input logic [7:0] a, input logic [7:0] e);
        exp_q.push_back({1'b0, e});
        send_byte(8'hBB, 2'b00); send_byte(a, 2'b00);
    endtask

    task automatic cmd_alu_ops(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f, input logic [15:0] e);
        regs_m[0] = a;
        regs_m[1] = b;
        exp_q.push_back({1'b0, e[7:0]});
        exp_q.push_back({1'b1, e[15:8]});
        send_byte(8'hCC, 2'b00); send_byte(a, 2'b00); send_byte(b, 2'b00); send_byte({4'h0, f}, 2'b00);
    endtask

    task automatic cmd_alu(input logic [3:0] f, input logic [15:0] e);
        exp_q.push_back({1'b0, e[7:0]});
        exp_q.push_back({1'b1, e[15:8]});
        send_byte(8'hDD, 2'b00); send_byte({4'h0, f}, 2'b00);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || BUSY || mon_busy) && n < 4000) begin
            @(negedge REF_CLK);
            n++;
        end
        checks++;
        if (n >= 4000) begin
            fails++;
            $display("FAIL %s: timeout waiting for idle, got %0d responses outstanding, expected 0", nm, exp_q.size());
        end
        repeat (4) @(negedge REF_CLK);
    endtask

    // Serial decoder: samples each TX bit mid-way and compares against exp_q.
    logic [7:0] m_d;
    logic m_st, m_sp, m_pb, m_gap;
    int m_t0, m_last = 0;
    exp_t m_e;
    initial begin
        forever begin
            @(negedge REF_CLK);
            if (RST === 1'b0 && TX_OUT === 1'b0) begin
                mon_busy = 1'b1;
                m_t0 = cyc;
                repeat (CPB / 2) @(negedge REF_CLK);
                m_st = TX_OUT;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge REF_CLK);
                    m_d[i] = TX_OUT;
                end
                m_pb = ^m_d;
`ifdef SYS_TOP_PARITY_EN
                repeat (CPB) @(negedge REF_CLK);
                m_pb = TX_OUT;
`endif
                repeat (CPB) @(negedge REF_CLK);
                m_sp = TX_OUT;
                if (!mon_ignore) begin
                    if (exp_q.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL tx_unexpected: got byte %02h, expected no response", m_d);
                    end else begin
                        m_e = exp_q.pop_front();
                        m_gap = !m_e.ch || ((m_t0 - m_last) == NBITS * CPB);
                        chk("tx_data", 32'(m_d), 32'(m_e.d));
                        chk("tx_framing{start,stop,par,gap}", {28'h0, m_st, m_sp, m_pb, m_gap},
                            {28'h0, 1'b0, 1'b1, ^m_d, 1'b1});
                        if (chk_busy && exp_q.size() == 0) begin
                            repeat (CPB / 2 - 1) @(negedge REF_CLK);
                            chk("busy_during_last_stop", 32'(BUSY), 1);
                            @(negedge REF_CLK);
                            chk("busy_after_last_stop", 32'(BUSY), 0);
                            chk_busy = 1'b0;
                        end
                    end
                end
                m_last = m_t0;
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        int n, sel;
        int p0, f0;
        logic [7:0] a, b;
        logic [3:0] f;
        RST = 1'b1;
        RX_IN = 1'b1;
        reset_model();
        repeat (5) @(negedge REF_CLK);
        chk("reset_tx_out", 32'(TX_OUT), 1);
        chk("reset_busy", 32'(BUSY), 0);
        chk("reset_par_err", 32'(PAR_ERR), 0);
        chk("reset_frm_err", 32'(FRM_ERR), 0);
        RST = 1'b0;
        repeat (5) @(negedge REF_CLK);

        chk_busy = 1'b1;
        exp_q.push_back({1'b0, 8'h81});
        send_byte(8'hBB, 2'b00);
        chk("busy_on_accept", 32'(BUSY), 1);
        send_byte(8'h02, 2'b00);
        wait_idle("read_reg2");
        chk("busy_check_reached", 32'(chk_busy), 0);

        cmd_write(8'h05, 8'h77);  wait_idle("write_reg5");
        cmd_read(8'h05, 8'h77);   wait_idle("read_reg5");

        cmd_alu_ops(8'h05, 8'h03, 4'h1, 16'h0002);  wait_idle("alu_sub");
        cmd_read(8'h00, 8'h05);  wait_idle("read_reg0");
        cmd_read(8'hF1, 8'h03);  wait_idle("read_reg1_upper_ignored");
        cmd_alu(4'h2, 16'h000F);  wait_idle("alu_mul");
        cmd_write(8'h01, 8'h00);  wait_idle("write_reg1_zero");
        cmd_alu(4'h3, 16'h0000);  wait_idle("alu_div0");

`ifdef SYS_TOP_PARITY_EN
        p0 = par_n;
        send_byte(8'hBB, 2'b01);
        repeat (10) @(negedge REF_CLK);
        chk("par_err_pulse_count", 32'(par_n - p0), 1);
        cmd_read(8'h02, 8'h81);  wait_idle("read_after_par_err");
`endif
        f0 = frm_n;
        p0 = par_n;
        send_byte(8'hBB, 2'b10);
        repeat (10) @(negedge REF_CLK);
        chk("frm_err_pulse_count", 32'(frm_n - f0), 1);
        cmd_read(8'h32, 8'h81);  wait_idle("read_after_frm_err");
        chk("no_par_err_on_good_frames", 32'(par_n - p0), 0);

        // read arrives while the ALU response is still on the wire
        cmd_alu_ops(8'h10, 8'h20, 4'h0, 16'h0030);
        cmd_read(8'h00, 8'h10);
        wait_idle("overlap");

        for (int k = 0; k < 30; k++) begin
            sel = $urandom_range(0, 4);
            a = 8'($urandom);
            b = 8'($urandom);
            f = 4'($urandom);
            case (sel)
                0: cmd_write(a, b);
                1: cmd_read(a, regs_m[a[3:0]]);
                2: cmd_alu_ops(a, b, f, alu_ref(a, b, f));
                3: cmd_alu(f, alu_ref(regs_m[0], regs_m[1], f));
                default: send_byte(8'($urandom_range(0, 159)), 2'b00);
            endcase
            wait_idle("random_cmd");
        end

        cmd_write(8'h03, 8'h55);  wait_idle("write_reg3");
        mon_ignore = 1'b1;
        send_byte(8'hBB, 2'b00);
        send_byte(8'h03, 2'b00);
        n = 0;
        while (TX_OUT !== 1'b0 && n < 100) begin
            @(negedge REF_CLK);
            n++;
        end
        chk("rst_tx_started", 32'(TX_OUT), 0);
        repeat (20) @(negedge REF_CLK);
        RST = 1'b1;
        @(posedge REF_CLK);
        #1;
        chk("rst_mid_tx_out", 32'(TX_OUT), 1);
        chk("rst_mid_busy", 32'(BUSY), 0);
        @(negedge REF_CLK);
        RST = 1'b0;
        reset_model();
        repeat (12 * CPB) @(negedge REF_CLK);
        mon_ignore = 1'b0;
        cmd_read(8'h03, 8'h20);  wait_idle("read_reg3_after_reset");

        chk("responses_all_seen", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
